// File: rtl/wave_rom_pkg.sv
// Shared definitions for the waveform ROM playback controller.
//   - ROM geometry constants (4 waveforms x 4096 samples x 8 bits)
//   - sequencer state encoding
//   - base-address helper for a waveform index
package wave_rom_pkg;

  localparam int unsigned NUM_WAVES        = 4;
  localparam int unsigned SAMPLES_PER_WAVE = 4096;
  localparam int unsigned ROM_ADDR_W       = 14;
  localparam int unsigned ROM_DATA_W       = 8;
  localparam int unsigned WAVE_IDX_W       = $clog2(NUM_WAVES);
  localparam int unsigned SAMPLE_IDX_W     = $clog2(SAMPLES_PER_WAVE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // First ROM address of waveform w.
  function automatic logic [ROM_ADDR_W-1:0] wave_base(input logic [WAVE_IDX_W-1:0] w);
    return ROM_ADDR_W'(w) << SAMPLE_IDX_W;
  endfunction

endpackage

// File: rtl/wave_rom_sequencer_phase_acc.sv
// Phase accumulator with period counter.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - zero phase and period count (new playback)
//   adv         - advance phase by step; count the wrap when it happens
//   step        - effective phase increment (never 0)
//   rep_eff     - effective periods per waveform (never 0)
//   phase       - current sample index within the waveform
//   wrap_c      - carry-out of phase + step this cycle
//   tc_c        - period count is at its last value (rep_eff-1)
module wave_phase_acc #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                adv,
  input  logic [SAMPLE_W-1:0] step,
  input  logic [REPEAT_W-1:0] rep_eff,
  output logic [SAMPLE_W-1:0] phase,
  output logic                wrap_c,
  output logic                tc_c
);

  logic [SAMPLE_W:0]   sum_c;
  logic [REPEAT_W-1:0] period_cnt;

  assign sum_c  = (SAMPLE_W+1)'(phase) + (SAMPLE_W+1)'(step);
  assign wrap_c = sum_c[SAMPLE_W];
  assign tc_c   = (period_cnt == (rep_eff - REPEAT_W'(1)));

  // Phase and period count; a terminal wrap restarts the count but keeps phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= '0;
      period_cnt <= '0;
    end else if (clear) begin
      phase      <= '0;
      period_cnt <= '0;
    end else if (adv) begin
      phase <= sum_c[SAMPLE_W-1:0];
      if (wrap_c) begin
        period_cnt <= tc_c ? '0 : period_cnt + REPEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wave_rom_sequencer.sv
// Waveform ROM playback sequencer.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   start, stop    - start request (IDLE only), abort request (RUN only)
//   wave_sel, step, repeat_cnt, auto_cycle - playback config, latched on start
//   rom_addr, rom_rden, rom_q - ROM read port ({cur_wave, phase})
//   sample_out, sample_valid  - realigned sample stream
//   cur_wave, busy, done      - status (done pulses on DRAIN->IDLE)
module wave_rom_sequencer
  import wave_rom_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned WAVE_W   = 2,
  parameter int unsigned DATA_W   = ROM_DATA_W,
  parameter int unsigned REPEAT_W = 4,
  parameter int unsigned ROM_LAT  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [WAVE_W-1:0]          wave_sel,
  input  logic [SAMPLE_W-1:0]        step,
  input  logic [REPEAT_W-1:0]        repeat_cnt,
  input  logic                       auto_cycle,
  output logic [WAVE_W+SAMPLE_W-1:0] rom_addr,
  output logic                       rom_rden,
  input  logic [DATA_W-1:0]          rom_q,
  output logic [DATA_W-1:0]          sample_out,
  output logic                       sample_valid,
  output logic [WAVE_W-1:0]          cur_wave,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned DRAIN_CYC   = ROM_LAT + 1;
  localparam int unsigned DRAIN_CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  seq_state_t state, next_state;

  logic [SAMPLE_W-1:0]    step_q;
  logic [REPEAT_W-1:0]    rep_q;
  logic                   auto_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [ROM_LAT:0]       vld_sr;
  logic [SAMPLE_W-1:0]    phase;
  logic                   wrap_c;
  logic                   tc_c;
  logic                   drain_last_c;

  logic acc_clear, acc_adv, wave_adv;
  logic rden_d, busy_d, done_d;

  wave_phase_acc #(
    .SAMPLE_W (SAMPLE_W),
    .REPEAT_W (REPEAT_W)
  ) u_phase_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (acc_clear),
    .adv     (acc_adv),
    .step    (step_q),
    .rep_eff (rep_q),
    .phase   (phase),
    .wrap_c  (wrap_c),
    .tc_c    (tc_c)
  );

  assign rom_addr     = {cur_wave, phase};
  assign sample_valid = vld_sr[ROM_LAT];
  assign drain_last_c = (drain_cnt == DRAIN_CNT_W'(DRAIN_CYC - 1));

  // State register, config latch, waveform index and registered status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_q    <= SAMPLE_W'(1);
      rep_q     <= REPEAT_W'(1);
      auto_q    <= 1'b0;
      cur_wave  <= '0;
      drain_cnt <= '0;
      rom_rden  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= next_state;
      rom_rden <= rden_d;
      busy     <= busy_d;
      done     <= done_d;
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_CNT_W'(1) : '0;
      if (acc_clear) begin
        cur_wave <= wave_sel;
        step_q   <= (step == '0) ? SAMPLE_W'(1) : step;
        rep_q    <= (repeat_cnt == '0) ? REPEAT_W'(1) : repeat_cnt;
        auto_q   <= auto_cycle;
      end else if (wave_adv) begin
        cur_wave <= cur_wave + WAVE_W'(1);
      end
    end
  end

  // Next state and next registered outputs; stop beats a terminal wrap.
  always_comb begin
    next_state = state;
    acc_clear  = 1'b0;
    acc_adv    = 1'b0;
    wave_adv   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          acc_clear  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          next_state = DRAIN;
        end else if (wrap_c && tc_c && !auto_q) begin
          next_state = DRAIN;
        end else begin
          acc_adv  = 1'b1;
          wave_adv = wrap_c && tc_c;
        end
      end
      DRAIN: begin
        if (drain_last_c) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    rden_d = (next_state == RUN);
    busy_d = (next_state != IDLE);
    done_d = (state == DRAIN) && (next_state == IDLE);
  end

  // Valid pipeline tracks each read; capture rom_q when its data is present.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr     <= '0;
      sample_out <= '0;
    end else begin
      vld_sr <= (ROM_LAT+1)'({vld_sr, rom_rden});
      if (vld_sr[ROM_LAT-1]) sample_out <= rom_q;
    end
  end

endmodule

// File: tb/tb_wave_rom_sequencer.sv
module tb_wave_rom_sequencer;
  import wave_rom_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, auto_cycle;
  logic [1:0]  wave_sel;
  logic [11:0] step;
  logic [3:0]  repeat_cnt;
  logic [13:0] rom_addr;
  logic        rom_rden;
  logic [7:0]  rom_q = 8'h00;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic [1:0]  cur_wave;
  logic        busy, done;

  int n_vec = 0;
  int n_miss = 0;

  int cyc = 0;
  int n_reads, n_samples, n_done, first_read_cyc, last_read_cyc, done_cyc;
  logic busy_prev;
  int rd_log[$];
  int pend_addr[$];
  int pend_cyc[$];

  wave_rom_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .wave_sel(wave_sel), .step(step), .repeat_cnt(repeat_cnt), .auto_cycle(auto_cycle),
    .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .cur_wave(cur_wave), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // One-cycle-latency ROM model.
  always @(posedge clk) if (rom_rden) rom_q <= rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: logs reads, scoreboards samples against issued reads.
  always @(negedge clk) begin
    cyc++;
    if (rom_rden) begin
      if (n_reads == 0) first_read_cyc = cyc;
      n_reads++;
      last_read_cyc = cyc;
      rd_log.push_back(int'(rom_addr));
      pend_addr.push_back(int'(rom_addr));
      pend_cyc.push_back(cyc);
    end
    if (sample_valid) begin
      n_samples++;
      if (pend_addr.size() == 0) begin
        check("samp_extra", 32'(pend_addr.size()), 32'd1);
      end else begin
        int a, c;
        a = pend_addr.pop_front();
        c = pend_cyc.pop_front();
        check("samp_data", 32'(sample_out), 32'(rom_fn(14'(a))));
        check("samp_lag", 32'(cyc - c), 32'd2);
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      check("busy_at_done", 32'(busy), 32'd0);
      check("busy_before_done", 32'(busy_prev), 32'd1);
    end
    busy_prev = busy;
  end

  task automatic clr_stats();
    n_reads = 0; n_samples = 0; n_done = 0;
    first_read_cyc = 0; last_read_cyc = 0; done_cyc = 0;
    rd_log.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  32'(rom_addr), 32'd0);
    check({tag, "_rden"},  32'(rom_rden), 32'd0);
    check({tag, "_sout"},  32'(sample_out), 32'd0);
    check({tag, "_svld"},  32'(sample_valid), 32'd0);
    check({tag, "_wave"},  32'(cur_wave), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
  endtask

  // Leaves the bench #1 into the first RUN cycle (read index 0).
  task automatic do_start(input logic [1:0] w, input logic [11:0] st,
                          input logic [3:0] rc, input logic ac);
    @(posedge clk); #1;
    start = 1'b1; wave_sel = w; step = st; repeat_cnt = rc; auto_cycle = ac;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_done == 0) check({tag, "_timeout"}, 32'(n_done), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    pend_addr.delete();
    pend_cyc.delete();
  endtask

  // Expected address sequence: each read advances phase by step with wave advance.
  task automatic check_seq(input string tag, input int w0, input int st, input int rc, input int n);
    int ph, w, cnt, errs, s;
    ph = 0; w = w0; cnt = 0; errs = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= rd_log.size() || rd_log[i] != (w * 4096 + ph)) errs++;
      s = ph + st;
      ph = s % 4096;
      if (s >= 4096) begin
        if (cnt == rc - 1) begin cnt = 0; w = (w + 1) % 4; end
        else cnt++;
      end
    end
    check({tag, "_seq_errs"}, 32'(errs), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; auto_cycle = 1'b0;
    wave_sel = '0; step = '0; repeat_cnt = '0;
    busy_prev = 1'b0;
    clr_stats();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    // wave 2, step 1, one period, single waveform.
    clr_stats();
    do_start(2'd2, 12'd1, 4'd1, 1'b0);
    check("t1_first_addr", 32'(rom_addr), 32'd8192);
    check("t1_first_rden", 32'(rom_rden), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 5000);
    check("t1_reads", 32'(n_reads), 32'd4096);
    check("t1_span", 32'(last_read_cyc - first_read_cyc), 32'd4095);
    check("t1_last_addr", 32'(rd_log[4095]), 32'd12287);
    check_seq("t1", 2, 1, 1, 4096);
    check("t1_samples", 32'(n_samples), 32'd4096);
    check("t1_done_cnt", 32'(n_done), 32'd1);
    check("t1_done_lag", 32'(done_cyc - last_read_cyc), 32'd3);

    // step 1024, 3 periods, auto cycle from wave 3; stop after 20 reads.
    clr_stats();
    do_start(2'd3, 12'd1024, 4'd3, 1'b1);
    repeat (19) @(posedge clk);
    #1;
    check("t2_addr19", 32'(rom_addr), 32'd3072);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("t2_rden_off", 32'(rom_rden), 32'd0);
    wait_done("t2", 50);
    check("t2_reads", 32'(n_reads), 32'd20);
    check("t2_addr11", 32'(rd_log[11]), 32'd15360);
    check("t2_addr12", 32'(rd_log[12]), 32'd0);
    check_seq("t2", 3, 1024, 3, 20);
    check("t2_samples", 32'(n_samples), 32'd20);
    check("t2_done_lag", 32'(done_cyc - last_read_cyc), 32'd3);
    check("t2_wave", 32'(cur_wave), 32'd0);

    // step 0 / repeat 0 behave as 1 / 1.
    clr_stats();
    do_start(2'd1, 12'd0, 4'd0, 1'b0);
    wait_done("t3", 5000);
    check("t3_reads", 32'(n_reads), 32'd4096);
    check_seq("t3", 1, 1, 1, 4096);
    check("t3_done_cnt", 32'(n_done), 32'd1);

    // step 4095 wraps every cycle after the first; repeat 2 -> 3 reads.
    clr_stats();
    do_start(2'd0, 12'd4095, 4'd2, 1'b0);
    wait_done("t4", 50);
    check("t4_reads", 32'(n_reads), 32'd3);
    check("t4_a1", 32'(rd_log[1]), 32'd4095);
    check("t4_a2", 32'(rd_log[2]), 32'd4094);
    check("t4_samples", 32'(n_samples), 32'd3);

    // stop coincides with the terminal wrap under auto cycle.
    clr_stats();
    do_start(2'd1, 12'd2048, 4'd1, 1'b1);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("t5_wave", 32'(cur_wave), 32'd1);
    check("t5_addr_hold", 32'(rom_addr), 32'd6144);
    check("t5_rden", 32'(rom_rden), 32'd0);
    wait_done("t5", 50);
    check("t5_reads", 32'(n_reads), 32'd2);
    check("t5_samples", 32'(n_samples), 32'd2);

    // reset in mid RUN.
    clr_stats();
    do_start(2'd2, 12'd1, 4'd1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    apply_reset();
    check_zero("rrun");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rrun_no_done", 32'(n_done), 32'd0);
    clr_stats();
    do_start(2'd3, 12'd2048, 4'd1, 1'b0);
    check("rrun_restart_addr", 32'(rom_addr), 32'd12288);
    wait_done("rrun", 50);
    check("rrun_reads", 32'(n_reads), 32'd2);
    check("rrun_done_cnt", 32'(n_done), 32'd1);

    // reset in DRAIN.
    clr_stats();
    do_start(2'd1, 12'd4095, 4'd1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rdrn_busy", 32'(busy), 32'd1);
    check("rdrn_rden", 32'(rom_rden), 32'd0);
    apply_reset();
    check_zero("rdrn");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rdrn_no_done", 32'(n_done), 32'd0);
    clr_stats();
    do_start(2'd2, 12'd2048, 4'd1, 1'b0);
    check("rdrn_restart_addr", 32'(rom_addr), 32'(wave_base(2'd2)));
    wait_done("rdrn", 50);
    check("rdrn_reads", 32'(n_reads), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wave_rom_sequencer.md
Name: wave_rom_sequencer

Overview:
Playback controller for the 16384x8 waveform ROM, which holds 4 waveforms of 4096 samples each, with waveform w at base address w*4096. It generates the ROM address and read-enable from a phase accumulator with a programmable step (frequency control). It plays a chosen waveform for a programmable number of periods, then either stops or advances to the next waveform. It realigns ROM read data into a registered sample stream with a valid flag.

Parameters:
SAMPLE_W, 12, log2 of samples per waveform (4096)
WAVE_W, 2, waveform index width (4 waveforms)
DATA_W, 8, ROM data width
REPEAT_W, 4, width of the periods-per-waveform count
ROM_LAT, 1, ROM read latency in clocks from registered address/rden to q valid

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle start request, honoured only in IDLE
stop  in  1  abort request, honoured in RUN
wave_sel  in  WAVE_W  first waveform to play, latched on start
step  in  SAMPLE_W  phase increment per clock, latched on start; 0 is treated as 1
repeat_cnt  in  REPEAT_W  periods per waveform, latched on start; 0 is treated as 1
auto_cycle  in  1  1: advance waveform after repeat_cnt periods and run until stop; 0: finish after one waveform; latched on start
rom_addr  out  WAVE_W+SAMPLE_W  ROM address, equal to {cur_wave, phase}
rom_rden  out  1  ROM read enable
rom_q  in  DATA_W  ROM read data
sample_out  out  DATA_W  registered sample
sample_valid  out  1  sample_out holds a new sample this cycle
cur_wave  out  WAVE_W  waveform currently being addressed
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, phase=0, period count=0. All outputs are 0: rom_addr, rom_rden, sample_out, sample_valid, cur_wave, busy, done. Valid pipeline is cleared.
- FSM states: IDLE, RUN, DRAIN. All outputs are registered.
- IDLE:
  - On start=1: latch configuration, set cur_wave=wave_sel, phase=0, period count=0, then go to RUN.
  - The first address {wave_sel,0} with rom_rden=1 appears the cycle after start.
- RUN:
  - rom_rden=1 on every cycle.
  - Each cycle, next phase = (phase + step_eff) mod 2^SAMPLE_W. A wrap is the carry-out of that add.
  - On wrap, when period count != repeat_eff-1: period count increments.
  - On wrap, when period count == repeat_eff-1:
    - auto_cycle=1: cur_wave <= cur_wave+1 (3 wraps to 0), period count <= 0, and the new phase is kept (no phase reset), so the waveform switch is glitch-free.
    - auto_cycle=0: go to DRAIN; rom_rden=0 from the next cycle.
  - On stop=1: go to DRAIN on the next edge. stop has priority over a simultaneous wrap, so no waveform advance occurs. The address issued in the stop cycle is still read.
  - start is ignored in RUN and DRAIN.
- DRAIN:
  - rom_rden=0, address holds.
  - Stay ROM_LAT+1 cycles so every issued read emerges on sample_out.
  - Then go to IDLE with done=1 for one cycle.
- Data path:
  - A valid shift register of length ROM_LAT+1 is fed by rom_rden.
  - sample_out <= rom_q when the stage-ROM_LAT tap is 1.
  - sample_valid is the final tap.
  - Net latency: sample_valid rises ROM_LAT+1 cycles after the matching rom_rden/rom_addr cycle, with exactly one valid per read, in order.
  - sample_out holds its last value when sample_valid=0.
- Reset mid-operation (any state): immediate return to reset values on the next edge, with no done pulse. In-flight samples are discarded (sample_valid=0).
- busy=1 in RUN and DRAIN. busy falls in the same cycle that done pulses.

Decomposition:
- Shared package wave_rom_pkg holds:
  - constants NUM_WAVES=4, SAMPLES_PER_WAVE=4096, ROM_ADDR_W=14, ROM_DATA_W=8;
  - the state enum typedef (IDLE, RUN, DRAIN);
  - a function for the base address of waveform w.
- One natural sub-module: wave_phase_acc, which holds the phase register, step add, wrap flag and the period counter with its terminal-count flag. The FSM, waveform index and valid pipeline stay in the top.

Test Plan:
- Reset then start with wave_sel=2, step=1, repeat_cnt=1, auto_cycle=0:
  - rom_addr runs 8192..12287, one per cycle, with rom_rden=1 for 4096 cycles.
  - sample_valid covers 4096 cycles, lagging by 2.
  - done pulses once; busy drops in the same cycle.
- step=1024, repeat_cnt=3, auto_cycle=1, wave_sel=3:
  - address phases 0,1024,2048,3072 repeat 3 times.
  - Then cur_wave wraps to 0 (addresses 0,1024,...).
  - Stop issued after 20 cycles: done pulses ROM_LAT+2 cycles later.
- step=0, repeat_cnt=0:
  - Behaves as step=1, repeat=1: exactly 4096 reads, then done.
- step=4095 (phase 0,4095,4094,...):
  - A wrap occurs on every cycle except the first.
  - With repeat_cnt=2, auto_cycle=0, the run lasts exactly 3 reads.
- stop asserted in the same cycle as the final wrap, with auto_cycle=1:
  - cur_wave does not advance; DRAIN is entered.
  - Sample count equals the read count.
- rst_n=0 in mid RUN, and again in DRAIN:
  - All outputs are 0 on the next cycle; no done pulse.
  - A start issued afterwards plays from wave_sel at address offset 0.
